// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS sequencer.
// Optional sweep feature is enabled with DDS_CTRL_SWEEP_EN.
package dds_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } dds_ctrl_state_t;

    localparam int LUT_DEPTH_DEF = 4096;
    localparam int STEP_W        = 32;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter; o_expire flags the last cycle of a dwell.
// Used by dds_ctrl only when DDS_CTRL_SWEEP_EN is defined.
module dds_dwell_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == W'(1));

endmodule

// File: rtl/dds_ctrl.sv
// DDS sequencer: streams the LUT from the host, then runs a tone or sweep.
// Define DDS_CTRL_SWEEP_EN to enable the dwell/increment sweep in RUN.
module dds_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int DWELL_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [7:0]         i_wr_data,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [STEP_W-1:0]  i_f_start,
    input  logic [STEP_W-1:0]  i_f_stop,
    input  logic [STEP_W-1:0]  i_f_inc,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [7:0]         o_cfg,
    output logic               o_cfg_ce,
    output logic [STEP_W-1:0]  o_step,
    output logic               o_busy,
    output logic               o_lut_loaded,
    output logic               o_done,
    output logic               o_err
);

    localparam int CNT_W = $clog2(LUT_DEPTH);

    dds_ctrl_state_t   r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr_ready;
    logic [7:0]        r_cfg;
    logic              r_cfg_ce;
    logic [STEP_W-1:0] r_step;
    logic              r_busy;
    logic              r_lut_loaded;
    logic              r_err;

    logic w_hs;
    logic w_last;
    logic w_accept;

    assign w_hs     = r_wr_ready && i_wr_valid;
    assign w_last   = w_hs && (r_cnt == CNT_W'(LUT_DEPTH - 1));
    assign w_accept = r_lut_loaded && (i_f_start != '0);

`ifdef DDS_CTRL_SWEEP_EN
    logic [STEP_W-1:0]  r_f_stop;
    logic [STEP_W-1:0]  r_f_inc;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_done;
    logic [DWELL_W-1:0] w_dwell_in;
    logic [STEP_W:0]    w_next;
    logic               w_end;
    logic               w_expire;
    logic               w_tmr_load;
    logic [DWELL_W-1:0] w_tmr_val;

    assign w_dwell_in = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    assign w_next     = {1'b0, r_step} + {1'b0, r_f_inc};
    // A carry out of the 32-bit add ends the sweep like passing f_stop.
    assign w_end      = w_next[STEP_W] || (w_next[STEP_W-1:0] > r_f_stop);
    assign w_tmr_val  = (r_state == S_IDLE) ? w_dwell_in : r_dwell;
    assign w_tmr_load = !i_abort && (
        ((r_state == S_IDLE) && !i_load && i_start && w_accept) ||
        ((r_state == S_RUN) && w_expire && !w_end));

    dds_dwell_timer #(.W(DWELL_W)) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (i_abort),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (r_state == S_RUN),
        .o_expire   (w_expire)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_f_stop <= '0;
            r_f_inc  <= '0;
            r_dwell  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!i_abort && (r_state == S_IDLE) && !i_load
                && i_start && w_accept) begin
                r_f_stop <= i_f_stop;
                r_f_inc  <= i_f_inc;
                r_dwell  <= w_dwell_in;
            end
            if (!i_abort && (r_state == S_RUN) && w_expire && w_end) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
`else
    logic w_unused;
    assign w_unused = ^{i_f_stop, i_f_inc, i_dwell};
    assign o_done   = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_ready   <= 1'b0;
            r_cfg        <= '0;
            r_cfg_ce     <= 1'b0;
            r_step       <= '0;
            r_busy       <= 1'b0;
            r_lut_loaded <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cfg_ce <= 1'b0;
            r_err    <= 1'b0;
            if (i_abort) begin
                r_state    <= S_IDLE;
                r_step     <= '0;
                r_wr_ready <= 1'b0;
                r_cnt      <= '0;
                r_busy     <= 1'b0;
                if ((r_state == S_PRIME) || (r_state == S_LOAD)) begin
                    r_lut_loaded <= 1'b0;
                end
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (i_load) begin
                            r_state      <= S_PRIME;
                            r_step       <= STEP_W'(1);
                            r_busy       <= 1'b1;
                            r_lut_loaded <= 1'b0;
                        end else if (i_start) begin
                            if (w_accept) begin
                                r_state <= S_RUN;
                                r_step  <= i_f_start;
                                r_busy  <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_PRIME: begin
                        r_state    <= S_LOAD;
                        r_step     <= '0;
                        r_wr_ready <= 1'b1;
                        r_cnt      <= '0;
                    end
                    S_LOAD: begin
                        if (w_hs) begin
                            r_cfg    <= i_wr_data;
                            r_cfg_ce <= 1'b1;
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                        if (w_last) begin
                            r_wr_ready   <= 1'b0;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_lut_loaded <= 1'b1;
                        end
                    end
                    S_RUN: begin
`ifdef DDS_CTRL_SWEEP_EN
                        if (w_expire) begin
                            if (w_end) begin
                                r_step  <= '0;
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_step <= w_next[STEP_W-1:0];
                            end
                        end
`endif
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_wr_ready   = r_wr_ready;
    assign o_cfg        = r_cfg;
    assign o_cfg_ce     = r_cfg_ce;
    assign o_step       = r_step;
    assign o_busy       = r_busy;
    assign o_lut_loaded = r_lut_loaded;
    assign o_err        = r_err;

endmodule

// File: tb/tb_dds_ctrl.sv
// Directed bench for dds_ctrl; covers both DDS_CTRL_SWEEP_EN builds.
module tb_dds_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_inc = '0;
    logic [15:0] dwell = '0;
    logic [7:0]  cfg;
    logic        cfg_ce;
    logic [31:0] step;
    logic        busy;
    logic        lut_loaded;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dds_ctrl #(.LUT_DEPTH(4096), .DWELL_W(16)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_load       (load),
        .i_wr_data    (wr_data),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_start      (start),
        .i_abort      (abort),
        .i_f_start    (f_start),
        .i_f_stop     (f_stop),
        .i_f_inc      (f_inc),
        .i_dwell      (dwell),
        .o_cfg        (cfg),
        .o_cfg_ce     (cfg_ce),
        .o_step       (step),
        .o_busy       (busy),
        .o_lut_loaded (lut_loaded),
        .o_done       (done),
        .o_err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic prime(input string tag);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk({tag, "_prime_step"}, step, 32'd1);
        chk({tag, "_prime_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_prime_loaded"}, {31'd0, lut_loaded}, 32'd0);
        tick();
        chk({tag, "_rdy"}, {31'd0, wr_ready}, 32'd1);
        chk({tag, "_step0"}, step, 32'd0);
        chk({tag, "_ce0"}, {31'd0, cfg_ce}, 32'd0);
    endtask

    task automatic stream(input int nbytes, input int stall_mod,
                          output int bad);
        logic [7:0] b;
        bad = 0;
        for (int i = 0; i < nbytes; i++) begin
            if (stall_mod != 0 && (i % stall_mod) == stall_mod - 1) begin
                wr_valid = 1'b0;
                tick();
                if (cfg_ce !== 1'b0) bad++;
            end
            b = 8'(i);
            wr_data  = b;
            wr_valid = 1'b1;
            tick();
            if (cfg_ce !== 1'b1 || cfg !== b) bad++;
            if (i < 4095 && wr_ready !== 1'b1) bad++;
            if (i < 4095 && lut_loaded !== 1'b0) bad++;
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [31:0] exp_step;

        repeat (3) tick();
        chk("rst_step", step, 32'd0);
        chk("rst_flags", {25'd0, wr_ready, cfg_ce, busy, lut_loaded,
                          done, err, 1'b0}, 32'd0);
        chk("rst_cfg", {24'd0, cfg}, 32'd0);
        rst = 1'b0;
        tick();

        f_start = 32'h0400_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rej_noload_err", {31'd0, err}, 32'd1);
        chk("rej_noload_step", step, 32'd0);
        chk("rej_noload_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rej_err_pulse", {31'd0, err}, 32'd0);

        prime("full");
        stream(4096, 0, bad);
        chk("full_bytes_bad", bad, 32'd0);
        chk("full_rdy_drop", {31'd0, wr_ready}, 32'd0);
        chk("full_loaded", {31'd0, lut_loaded}, 32'd1);
        chk("full_busy", {31'd0, busy}, 32'd0);
        chk("full_step", step, 32'd0);
        tick();
        chk("full_ce_end", {31'd0, cfg_ce}, 32'd0);

        f_start = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rej_zero_err", {31'd0, err}, 32'd1);
        chk("rej_zero_busy", {31'd0, busy}, 32'd0);
        chk("rej_zero_step", step, 32'd0);

        f_start = 32'h0400_0000;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_prio_err", {31'd0, err}, 32'd0);
        chk("abort_prio_busy", {31'd0, busy}, 32'd0);

`ifdef DDS_CTRL_SWEEP_EN
        f_start = 32'h1000_0000;
        f_inc   = 32'h0100_0000;
        f_stop  = 32'h1300_0000;
        dwell   = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_step = 32'h1000_0000 + (32'(k / 3) << 24);
            chk("sweep_step", step, exp_step);
            chk("sweep_nodone", {31'd0, done}, 32'd0);
            tick();
        end
        chk("sweep_end_step", step, 32'd0);
        chk("sweep_done", {31'd0, done}, 32'd1);
        chk("sweep_end_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("sweep_done_pulse", {31'd0, done}, 32'd0);

        f_start = 32'hFFFF_FF00;
        f_inc   = 32'h0000_0200;
        f_stop  = 32'hFFFF_FFFF;
        dwell   = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_step0", step, 32'hFFFF_FF00);
        tick();
        chk("ovf_step1", step, 32'hFFFF_FF00);
        chk("ovf_nodone", {31'd0, done}, 32'd0);
        tick();
        chk("ovf_end_step", step, 32'd0);
        chk("ovf_done", {31'd0, done}, 32'd1);
`else
        f_start = 32'h0400_0000;
        f_inc   = 32'h0100_0000;
        f_stop  = 32'h0000_0001;
        dwell   = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_step", step, 32'h0400_0000);
        chk("hold_busy", {31'd0, busy}, 32'd1);
        bad = 0;
        for (int k = 0; k < 1100; k++) begin
            tick();
            if (step !== 32'h0400_0000 || done !== 1'b0) bad++;
        end
        chk("hold_bad", bad, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("hold_abort_step", step, 32'd0);
        chk("hold_abort_busy", {31'd0, busy}, 32'd0);
        chk("hold_abort_loaded", {31'd0, lut_loaded}, 32'd1);
        chk("hold_abort_done", {31'd0, done}, 32'd0);
`endif

        prime("part");
        stream(100, 0, bad);
        chk("part_bytes_bad", bad, 32'd0);
        abort = 1'b1;
        wr_valid = 1'b1;
        tick();
        abort = 1'b0;
        wr_valid = 1'b0;
        chk("part_abort_rdy", {31'd0, wr_ready}, 32'd0);
        chk("part_abort_loaded", {31'd0, lut_loaded}, 32'd0);
        chk("part_abort_ce", {31'd0, cfg_ce}, 32'd0);
        chk("part_abort_busy", {31'd0, busy}, 32'd0);

        prime("reload");
        stream(4096, 7, bad);
        chk("reload_bytes_bad", bad, 32'd0);
        chk("reload_loaded", {31'd0, lut_loaded}, 32'd1);
        chk("reload_rdy", {31'd0, wr_ready}, 32'd0);
        chk("reload_busy", {31'd0, busy}, 32'd0);

        load = 1'b1;
        start = 1'b1;
        f_start = 32'h0400_0000;
        tick();
        load = 1'b0;
        start = 1'b0;
        chk("both_load_wins", step, 32'd1);
        chk("both_no_err", {31'd0, err}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("prime_abort_loaded", {31'd0, lut_loaded}, 32'd0);
        chk("prime_abort_step", step, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
